// File: rtl/demux_1_2_stream.sv
// -----------------------------------------------------------------------------
// demux_1_2_stream
//
// Purpose:
//   1-to-2 stream demultiplexer. Each accepted input word is steered by its
//   s_sel bit into one of two independent DEPTH-entry FIFOs. Each FIFO drives
//   its own valid/ready output lane. A stalled consumer therefore blocks only
//   the words addressed to it; the other lane keeps flowing.
//
// Ports:
//   clk                      rising-edge clock
//   rst                      synchronous, active-high reset (empties both FIFOs)
//   s_valid / s_ready        input handshake; a word is taken when both are 1
//   s_sel                    destination lane of s_data (0 -> y0, 1 -> y1)
//   s_data  [WIDTH]          input word
//   y0_valid / y0_ready      lane 0 handshake (valid = FIFO 0 non-empty)
//   y0_data [WIDTH]          lane 0 FIFO head, forced to 0 while empty
//   y0_count                 lane 0 occupancy, 0..DEPTH
//   y1_*                     same as y0_* for lane 1
// -----------------------------------------------------------------------------
module demux_1_2_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       s_sel,
  input  logic [WIDTH-1:0]           s_data,
  output logic                       y0_valid,
  input  logic                       y0_ready,
  output logic [WIDTH-1:0]           y0_data,
  output logic [$clog2(DEPTH+1)-1:0] y0_count,
  output logic                       y1_valid,
  input  logic                       y1_ready,
  output logic [WIDTH-1:0]           y1_data,
  output logic [$clog2(DEPTH+1)-1:0] y1_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [1:0]       w_full;
  logic [1:0]       w_valid;
  logic [1:0]       w_out_ready;
  logic [WIDTH-1:0] w_data  [2];
  logic [CW-1:0]    w_count [2];

  assign w_out_ready = {y1_ready, y0_ready};

  // Only the addressed lane's fullness matters, and fullness comes from the
  // registered count, so consumer ready never reaches s_ready.
  assign s_ready = ~w_full[s_sel];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [WIDTH-1:0] r_mem [DEPTH];
      logic [PW-1:0]    r_wr_ptr;
      logic [PW-1:0]    r_rd_ptr;
      logic [CW-1:0]    r_count;
      logic             w_push;
      logic             w_pop;

      assign w_push = s_valid & s_ready & (s_sel == 1'(gi));
      assign w_pop  = w_valid[gi] & w_out_ready[gi];

      // Pointers are exactly log2(DEPTH) bits, so natural overflow gives the
      // DEPTH-1 -> 0 wrap. Count can never pass DEPTH or drop below 0 because
      // push is gated by ~full and pop by valid.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
          end
          if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
          end
          case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
          endcase
        end
      end

      // Storage has no reset: stale entries are never visible because the
      // output is masked whenever the lane is empty.
      always_ff @(posedge clk) begin
        if (!rst && w_push) begin
          r_mem[r_wr_ptr] <= s_data;
        end
      end

      assign w_full[gi]  = (r_count == CW'(DEPTH));
      assign w_valid[gi] = (r_count != '0);
      assign w_data[gi]  = w_valid[gi] ? r_mem[r_rd_ptr] : '0;
      assign w_count[gi] = r_count;
    end
  endgenerate

  assign y0_valid = w_valid[0];
  assign y0_data  = w_data[0];
  assign y0_count = w_count[0];
  assign y1_valid = w_valid[1];
  assign y1_data  = w_data[1];
  assign y1_count = w_count[1];

endmodule

// File: tb/tb_demux_1_2_stream.sv
module tb_demux_1_2_stream;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic             s_sel = 1'b0;
  logic [WIDTH-1:0] s_data = '0;
  logic             y0_valid;
  logic             y0_ready = 1'b0;
  logic [WIDTH-1:0] y0_data;
  logic [CW-1:0]    y0_count;
  logic             y1_valid;
  logic             y1_ready = 1'b0;
  logic [WIDTH-1:0] y1_data;
  logic [CW-1:0]    y1_count;

  int n_checks = 0;
  int n_fail   = 0;

  demux_1_2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_sel(s_sel), .s_data(s_data),
    .y0_valid(y0_valid), .y0_ready(y0_ready), .y0_data(y0_data), .y0_count(y0_count),
    .y1_valid(y1_valid), .y1_ready(y1_ready), .y1_data(y1_data), .y1_count(y1_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Directed vectors: inputs for one cycle plus the outputs expected during
  // that cycle (before the edge that consumes the inputs).
  typedef struct {
    bit         chk;
    logic       rst, v, sel;
    logic [7:0] d;
    logic       r0, r1;
    logic       e_rdy;
    logic       e_v0;
    logic [7:0] e_d0;
    int         e_c0;
    logic       e_v1;
    logic [7:0] e_d1;
    int         e_c1;
  } vec_t;

  vec_t tbl[17];

  // Reference model: one queue per lane.
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];

  task automatic drive(input logic r, input logic v, input logic sel,
                       input logic [7:0] d, input logic r0, input logic r1);
    rst = r; s_valid = v; s_sel = sel; s_data = d; y0_ready = r0; y1_ready = r1;
  endtask

  // One cycle against the queue model: compare, then advance model and DUT.
  task automatic mcycle(input bit do_chk, input logic r, input logic v, input logic sel,
                        input logic [7:0] d, input logic r0, input logic r1,
                        output bit accepted);
    bit e_rdy;
    bit pop0, pop1;
    drive(r, v, sel, d, r0, r1);
    #2;
    e_rdy = sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    if (do_chk) begin
      chk("m_s_ready",  int'(s_ready),  int'(e_rdy));
      chk("m_y0_valid", int'(y0_valid), int'(q0.size() != 0));
      chk("m_y0_data",  int'(y0_data),  (q0.size() != 0) ? int'(q0[0]) : 0);
      chk("m_y0_count", int'(y0_count), q0.size());
      chk("m_y1_valid", int'(y1_valid), int'(q1.size() != 0));
      chk("m_y1_data",  int'(y1_data),  (q1.size() != 0) ? int'(q1[0]) : 0);
      chk("m_y1_count", int'(y1_count), q1.size());
      chk("m_y0_le_depth", int'(y0_count <= CW'(DEPTH)), 1);
      chk("m_y1_le_depth", int'(y1_count <= CW'(DEPTH)), 1);
    end
    accepted = !r && v && e_rdy;
    pop0 = (q0.size() != 0) && r0;
    pop1 = (q1.size() != 0) && r1;
    @(posedge clk);
    #1;
    if (r) begin
      q0.delete();
      q1.delete();
    end else begin
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (accepted) begin
        if (sel) q1.push_back(d);
        else     q0.push_back(d);
      end
    end
  endtask

  initial begin
    bit acc;
    int words;
    int cyc;

    //            chk rst v sel d      r0 r1 rdy v0 d0     c0 v1 d1     c1
    // Reset held two cycles with s_valid high: nothing may be pushed.
    tbl[0]  = '{0, 1, 1, 0, 8'h11, 0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0};
    tbl[1]  = '{1, 1, 1, 0, 8'h22, 0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0};
    tbl[2]  = '{1, 0, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0};
    // Routing: A5->y0, 3C->y1, 7E->y0, each visible one cycle after accept.
    tbl[3]  = '{1, 0, 1, 0, 8'hA5, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0};
    tbl[4]  = '{1, 0, 1, 1, 8'h3C, 1, 1, 1, 1, 8'hA5, 1, 0, 8'h00, 0};
    tbl[5]  = '{1, 0, 1, 0, 8'h7E, 1, 1, 1, 0, 8'h00, 0, 1, 8'h3C, 1};
    tbl[6]  = '{1, 0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h7E, 1, 0, 8'h00, 0};
    tbl[7]  = '{1, 0, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0};
    // Fill y0 with its consumer stalled; fifth word refused.
    tbl[8]  = '{1, 0, 1, 0, 8'h01, 0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0};
    tbl[9]  = '{1, 0, 1, 0, 8'h02, 0, 0, 1, 1, 8'h01, 1, 0, 8'h00, 0};
    tbl[10] = '{1, 0, 1, 0, 8'h03, 0, 0, 1, 1, 8'h01, 2, 0, 8'h00, 0};
    tbl[11] = '{1, 0, 1, 0, 8'h04, 0, 0, 1, 1, 8'h01, 3, 0, 8'h00, 0};
    tbl[12] = '{1, 0, 1, 0, 8'h05, 0, 0, 0, 1, 8'h01, 4, 0, 8'h00, 0};
    // y0 full, but a word for y1 still goes through.
    tbl[13] = '{1, 0, 1, 1, 8'h66, 0, 0, 1, 1, 8'h01, 4, 0, 8'h00, 0};
    // Full with pop: only the pop happens, the push lands the next cycle.
    tbl[14] = '{1, 0, 1, 0, 8'h05, 1, 0, 0, 1, 8'h01, 4, 1, 8'h66, 1};
    tbl[15] = '{1, 0, 1, 0, 8'h05, 1, 0, 1, 1, 8'h02, 3, 1, 8'h66, 1};
    tbl[16] = '{1, 0, 0, 0, 8'h00, 0, 0, 1, 1, 8'h03, 3, 1, 8'h66, 1};

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1);
      #2;
      if (tbl[i].chk) begin
        chk($sformatf("v%0d_s_ready", i),  int'(s_ready),  int'(tbl[i].e_rdy));
        chk($sformatf("v%0d_y0_valid", i), int'(y0_valid), int'(tbl[i].e_v0));
        chk($sformatf("v%0d_y0_data", i),  int'(y0_data),  int'(tbl[i].e_d0));
        chk($sformatf("v%0d_y0_count", i), int'(y0_count), tbl[i].e_c0);
        chk($sformatf("v%0d_y1_valid", i), int'(y1_valid), int'(tbl[i].e_v1));
        chk($sformatf("v%0d_y1_data", i),  int'(y1_data),  int'(tbl[i].e_d1));
        chk($sformatf("v%0d_y1_count", i), int'(y1_count), tbl[i].e_c1);
      end
      @(posedge clk);
      #1;
    end

    // Resynchronise the model with a reset cycle (DUT still holds table data).
    mcycle(0, 1, 0, 0, 8'h00, 0, 0, acc);

    // Wrap-around: 20 words with alternating select, random consumers.
    words = 0;
    cyc = 0;
    while (words < 20 && cyc < 400) begin
      mcycle(1, 0, ($urandom_range(0, 3) != 0), words[0], 8'($urandom),
             1'($urandom), 1'($urandom), acc);
      if (acc) words++;
      cyc++;
    end
    chk("rand_words_sent", words, 20);

    // Longer random run with random select to exercise pointer wrap further.
    for (int i = 0; i < 200; i++) begin
      mcycle(1, 0, 1'($urandom), 1'($urandom), 8'($urandom),
             ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0), acc);
    end
    for (int i = 0; i < 10; i++) begin
      mcycle(1, 0, 0, 0, 8'h00, 1, 1, acc);
    end

    // Mid-stream reset with three words buffered on y1.
    mcycle(1, 0, 1, 1, 8'hB1, 0, 0, acc);
    mcycle(1, 0, 1, 1, 8'hB2, 0, 0, acc);
    mcycle(1, 0, 1, 1, 8'hB3, 0, 0, acc);
    mcycle(1, 1, 1, 1, 8'hB4, 1, 0, acc);
    chk("rst_y1_count", int'(y1_count), 0);
    chk("rst_y1_valid", int'(y1_valid), 0);
    mcycle(1, 0, 1, 1, 8'hC7, 0, 1, acc);
    chk("post_rst_y1_data", int'(y1_data), 32'hC7);
    mcycle(1, 0, 0, 1, 8'h00, 0, 1, acc);
    mcycle(1, 0, 0, 0, 8'h00, 1, 1, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
